alarm_ctrl: RTL
===============

# alarm_ctrl

Sequencing controller for the alarm-blink datapath of the digital clock. Holds the programmed alarm time and compares it against the running clock time. Owns the ring/snooze/dismiss state machine and drives the single `alarmFlag` level consumed by the LED blink stage. Sits between the timekeeping counters and button debouncers on one side and the alarm LED driver on the other.

## Interface

**Parameters**
- `RING_SEC`, default 60: seconds the alarm rings before it auto-stops.
- `SNOOZE_SEC`, default 300: snooze length in seconds.
- `MAX_SNOOZE`, default 3: snoozes allowed per alarm event.

**Ports**
- `CLK` in, 1 bit: system clock.
- `RST_N` in, 1 bit: synchronous, active-low reset.
- `tick_1hz` in, 1 bit: one-`CLK`-wide pulse once per second.
- `cur_hr` in, 5 bits: current hour, 0–23.
- `cur_min` in, 6 bits: current minute, 0–59.
- `cur_sec` in, 6 bits: current second, 0–59.
- `set_en` in, 1 bit: one-cycle pulse that loads `set_hr`/`set_min` as the alarm time.
- `set_hr` in, 5 bits: new alarm hour.
- `set_min` in, 6 bits: new alarm minute.
- `arm` in, 1 bit: level; 1 = alarm enabled.
- `snooze` in, 1 bit: debounced one-cycle pulse.
- `dismiss` in, 1 bit: debounced one-cycle pulse.
- `alarmFlag` out, 1 bit: registered; 1 while ringing.
- `snoozing` out, 1 bit: registered; 1 while in SNOOZE.
- `alm_hr` out, 5 bits: stored alarm hour.
- `alm_min` out, 6 bits: stored alarm minute.

## Operation

- **States:** DISARMED, ARMED, RINGING, SNOOZE.
- **Reset values:** state = DISARMED, `alarmFlag` = 0, `snoozing` = 0, `alm_hr` = 0, `alm_min` = 0, second counter = 0, snooze count = 0.
- **Match:**
  - `match` = (`cur_hr` == `alm_hr`) && (`cur_min` == `alm_min`) && (`cur_sec` == 0).
  - A trigger is the rising edge of `match` (`match` && !`match_d`), so the alarm fires once per minute-match. Re-entering ARMED during the same matching second does not retrigger.
- **Transitions, highest priority first:**
  - `arm` == 0: any state -> DISARMED. Counters and snooze count are cleared.
  - DISARMED -> ARMED when `arm` == 1.
  - ARMED -> RINGING on trigger. The second counter is loaded with `RING_SEC`; snooze count is cleared.
  - RINGING -> ARMED on `dismiss`.
  - RINGING -> SNOOZE on `snooze` when snooze count < `MAX_SNOOZE`. The counter is loaded with `SNOOZE_SEC`; snooze count increments. When snooze count == `MAX_SNOOZE`, `snooze` is ignored.
  - RINGING -> ARMED when the counter reaches 0 on a `tick_1hz`.
  - SNOOZE -> ARMED on `dismiss`.
  - SNOOZE -> RINGING when the counter reaches 0 on a `tick_1hz`. The counter is reloaded with `RING_SEC`.
- **Simultaneous events:**
  - `dismiss` beats `snooze`.
  - `dismiss` or `snooze` beats counter expiry in the same cycle.
- **Counter:** decrements only on `tick_1hz`. Width is `$clog2(max(RING_SEC,SNOOZE_SEC)+1)`. It never wraps below 0.
- **`set_en`:** updates `alm_hr`/`alm_min` in any state without changing state.
  - Values out of range (hr > 23, min > 59) are rejected and the old value is kept.
  - A new time equal to the current time triggers on the next `match` rising edge only.
- **Outputs:** `alarmFlag` = (state == RINGING) and `snoozing` = (state == SNOOZE), both registered from the next-state value.

## Timing

- Trigger to `alarmFlag` = 1: one `CLK` after the cycle in which `match` first goes true.
- `dismiss` or `snooze` pulse in cycle N: `alarmFlag` = 0 at N+1.
- Ring duration: exactly `RING_SEC` `tick_1hz` pulses after entry. Expiry happens on the `RING_SEC`-th tick, and `alarmFlag` falls the following cycle.
- Snooze duration: the same rule applies with `SNOOZE_SEC`.
- `arm` falling: DISARMED and all outputs 0 one cycle later.
- `RST_N` low on a rising `CLK` edge: reset values next cycle, including mid-RINGING and mid-SNOOZE.

## Configuration

- **`ALARM_SNOOZE_EN` defined:** snooze behaves as described above.
- **`ALARM_SNOOZE_EN` undefined:**
  - The `snooze` input is ignored and the SNOOZE state and snooze counter are not built.
  - `snoozing` is tied to 0.
  - In RINGING, only `dismiss`, expiry and `arm` take effect.

## Structure

- **Package `alarm_pkg`:** the state enum (DISARMED = 0, ARMED = 1, RINGING = 2, SNOOZE = 3), plus constants `HR_MAX` = 23 and `MIN_MAX` = 59.
- **Sub-module `sec_countdown`:** a loadable down-counter advanced by `tick_1hz`, with a `load`/`value` interface and a `zero` flag. It is used once, for both ring and snooze timing.

## Test plan

1. **Reset and ring timeout.** Reset, `arm` = 1, set alarm to 07:30, drive time to 07:30:00 -> `alarmFlag` = 1 one cycle later. After 60 ticks, `alarmFlag` = 0 and state = ARMED.
2. **Snooze limit.** While RINGING, pulse `snooze` -> `snoozing` = 1 and `alarmFlag` = 0. After 300 ticks, RINGING again. A 4th `snooze` with `MAX_SNOOZE` = 3 is ignored.
3. **Simultaneous buttons.** `snooze` and `dismiss` in the same cycle while RINGING -> state = ARMED and `snoozing` = 0.
4. **Disarm mid-snooze.** Drop `arm` in SNOOZE -> DISARMED next cycle. A later match at 07:30:00 produces no ring.
5. **Range check.** `set_en` with 24:00 -> `alm_hr`/`alm_min` unchanged. `set_en` with 23:59 -> loaded.
6. **Reset mid-ring.** `RST_N` = 0 while RINGING -> `alarmFlag` = 0 and `alm_hr`/`alm_min` = 0 next cycle. With `ALARM_SNOOZE_EN` undefined, `snooze` while RINGING leaves `alarmFlag` = 1.

Source files
------------

// File: rtl/alarm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// alarm_pkg : state enum and time-of-day limits shared by alarm_ctrl
// Rev 1.0
// ----------------------------------------------------------------------
package alarm_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } alarm_state_t;

  localparam logic [4:0] HR_MAX  = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sec_countdown.sv
`default_nettype none
// ----------------------------------------------------------------------
// sec_countdown : loadable seconds down-counter, saturates at zero
// Rev 1.0
// ----------------------------------------------------------------------
module sec_countdown #(
  parameter int WIDTH = 9
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] r_value;

  // load wins over a coincident tick so a fresh period starts with its full count
  always_ff @(posedge CLK) begin
    if (!RST_N || clr) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= load_val;
    end else if (tick && (r_value != '0)) begin
      r_value <= r_value - WIDTH'(1);
    end
  end

  assign value = r_value;
  assign zero  = (r_value == '0);

endmodule
`default_nettype wire

// File: rtl/alarm_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------
// alarm_ctrl : alarm time store, match detect and ring/snooze/dismiss FSM
// Optional snooze support built when ALARM_SNOOZE_EN is defined. Rev 1.0
// ----------------------------------------------------------------------
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hr,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic       set_en,
  input  logic [4:0] set_hr,
  input  logic [5:0] set_min,
  input  logic       arm,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       alarmFlag,
  output logic       snoozing,
  output logic [4:0] alm_hr,
  output logic [5:0] alm_min
);

  localparam int c_cnt_w = $clog2(max_int(RING_SEC, SNOOZE_SEC) + 1);

  alarm_state_t       r_state;
  alarm_state_t       w_next;
  logic [4:0]         r_alm_hr;
  logic [5:0]         r_alm_min;
  logic               r_match_d;
  logic               r_alarm_flag;
  logic               w_match;
  logic               w_trigger;
  logic               w_expire;
  logic               w_cnt_load;
  logic               w_cnt_clr;
  logic [c_cnt_w-1:0] w_load_val;
  logic [c_cnt_w-1:0] w_cnt_val;
  logic               w_cnt_zero;

`ifdef ALARM_SNOOZE_EN
  localparam int                 c_snz_w   = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);
  localparam logic [c_snz_w-1:0] c_max_snz = c_snz_w'(MAX_SNOOZE);

  logic [c_snz_w-1:0] r_snz_cnt;
  logic               r_snoozing;
  logic               w_snz_inc;
  logic               w_snz_clr;
`else
  localparam int c_unused_max_snooze = MAX_SNOOZE;
  logic w_unused_snooze;
  assign w_unused_snooze = snooze;
`endif

  // rising edge only, so one minute-match fires once even if ARMED is re-entered
  assign w_match   = (cur_hr == r_alm_hr) && (cur_min == r_alm_min) && (cur_sec == 6'd0);
  assign w_trigger = w_match && !r_match_d;
  assign w_expire  = tick_1hz && (w_cnt_zero || (w_cnt_val == c_cnt_w'(1)));

  sec_countdown #(
    .WIDTH (c_cnt_w)
  ) u_sec_countdown (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clr      (w_cnt_clr),
    .load     (w_cnt_load),
    .load_val (w_load_val),
    .tick     (tick_1hz),
    .value    (w_cnt_val),
    .zero     (w_cnt_zero)
  );

  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_clr  = 1'b0;
    w_load_val = c_cnt_w'(RING_SEC);
`ifdef ALARM_SNOOZE_EN
    w_snz_inc  = 1'b0;
    w_snz_clr  = 1'b0;
`endif
    if (!arm) begin
      w_next    = DISARMED;
      w_cnt_clr = 1'b1;
`ifdef ALARM_SNOOZE_EN
      w_snz_clr = 1'b1;
`endif
    end else begin
      case (r_state)
        DISARMED: w_next = ARMED;
        ARMED: begin
          if (w_trigger) begin
            w_next     = RINGING;
            w_cnt_load = 1'b1;
`ifdef ALARM_SNOOZE_EN
            w_snz_clr  = 1'b1;
`endif
          end
        end
        RINGING: begin
          // button presses take priority over a coincident expiry
          if (dismiss) begin
            w_next = ARMED;
          end
`ifdef ALARM_SNOOZE_EN
          else if (snooze && (r_snz_cnt < c_max_snz)) begin
            w_next     = SNOOZE;
            w_cnt_load = 1'b1;
            w_load_val = c_cnt_w'(SNOOZE_SEC);
            w_snz_inc  = 1'b1;
          end
`endif
          else if (w_expire) begin
            w_next = ARMED;
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (dismiss) begin
            w_next = ARMED;
          end else if (w_expire) begin
            w_next     = RINGING;
            w_cnt_load = 1'b1;
          end
        end
`endif
        default: w_next = DISARMED;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state      <= DISARMED;
      r_alarm_flag <= 1'b0;
      r_match_d    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_alarm_flag <= (w_next == RINGING);
      r_match_d    <= w_match;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_alm_hr  <= 5'd0;
      r_alm_min <= 6'd0;
    end else if (set_en && (set_hr <= HR_MAX) && (set_min <= MIN_MAX)) begin
      r_alm_hr  <= set_hr;
      r_alm_min <= set_min;
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_snz_cnt  <= '0;
      r_snoozing <= 1'b0;
    end else begin
      r_snoozing <= (w_next == SNOOZE);
      if (w_snz_clr) begin
        r_snz_cnt <= '0;
      end else if (w_snz_inc) begin
        r_snz_cnt <= r_snz_cnt + c_snz_w'(1);
      end
    end
  end

  assign snoozing = r_snoozing;
`else
  assign snoozing = 1'b0;
`endif

  assign alarmFlag = r_alarm_flag;
  assign alm_hr    = r_alm_hr;
  assign alm_min   = r_alm_min;

endmodule
`default_nettype wire
